// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage boundary registers:
//   - stage_state_e : occupancy state of a pipe_skid_stage (2-bit encoding)
//   - NOP_INSTR     : all-zero instruction word used as the default bubble
//   - *_WIDTH       : payload width of each stage boundary
//   - occupancy_of  : maps a state to its held-entry count
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held
    ST_FULL  = 2'd1,  // main register valid
    ST_SKID  = 2'd2   // main and skid registers both valid
  } stage_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // IF/ID carries {pc_plus_4, instruction}; the later boundaries carry the
  // decoded/execute bundles owned by the consuming stages.
  localparam int IF_ID_WIDTH  = 64;
  localparam int ID_EX_WIDTH  = 128;
  localparam int EX_MEM_WIDTH = 104;
  localparam int MEM_WB_WIDTH = 72;

  function automatic logic [1:0] occupancy_of(input stage_state_e st);
    case (st)
      ST_FULL: occupancy_of = 2'd1;
      ST_SKID: occupancy_of = 2'd2;
      default: occupancy_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
// Pipeline boundary register with valid/ready handshake and a one-entry skid
// buffer. in_ready is registered (derived from next state), so downstream
// backpressure never reaches upstream combinationally; the skid register
// absorbs the entry upstream already committed in the cycle ready drops.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   clk_en     in   global step enable; low = no handshake, state holds
//   flush      in   synchronous discard of all held entries (beats clk_en)
//   in_valid   in   upstream presents in_data
//   in_ready   out  stage can accept (registered)
//   in_data    in   upstream payload [WIDTH]
//   out_valid  out  out_data holds a valid entry
//   out_ready  in   downstream accepts
//   out_data   out  head payload, BUBBLE when out_valid = 0 [WIDTH]
//   occupancy  out  number of held entries (0..2)
// ---------------------------------------------------------------------------
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = IF_ID_WIDTH,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       occ_q;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid  & in_ready_q  & clk_en & ~flush;
  assign out_fire = out_valid_q & out_ready & clk_en & ~flush;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; an unassigned path in always_comb infers a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Skid contents become don't-care once the state says they are invalid.
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          if (in_fire && !out_fire) begin
            state_d = ST_SKID;
            skid_d  = in_data;
          end else if (in_fire && out_fire) begin
            main_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so in_fire cannot occur.
          if (out_fire) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
        end
      endcase
    end
  end

  // Handshake outputs are registered from the next state so they settle right
  // after the edge and never depend on out_ready within a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      state_q     <= state_d;
      main_q      <= main_d;
      in_ready_q  <= (state_d != ST_SKID);
      out_valid_q <= (state_d != ST_EMPTY);
      occ_q       <= occupancy_of(state_d);
    end
  end

  // NOTE: the skid data register is deliberately not reset; its contents are
  // only observed while the state marks it valid, so a reset adds nothing.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_stage
// Directed bench for pipe_skid_stage: streaming, single and long stalls,
// flush from SKID, clk_en gating (with flush overriding it) and asynchronous
// reset while holding an entry. Expected values are written out by hand.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_skid_stage;

  localparam int               W         = 64;
  localparam logic [W-1:0]     TB_BUBBLE = 64'hFFFF_0000_0000_0013;

  logic         clk;
  logic         reset;
  logic         clk_en;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int checks   = 0;
  int failures = 0;

  pipe_skid_stage #(.WIDTH(W), .BUBBLE(TB_BUBBLE)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int low_cnt;

    reset     = 1'b1;
    clk_en    = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  out_data,       TB_BUBBLE);
    check("rst_occupancy", 64'(occupancy), 64'd0);

    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // ---- stream 1..5 at full throughput ----
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_data = 64'(i);
      tick();
      check($sformatf("stream_data_%0d", i), out_data,       64'(i));
      check($sformatf("stream_occ_%0d", i),  64'(occupancy), 64'd1);
      check($sformatf("stream_rdy_%0d", i),  64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", 64'(out_valid), 64'd0);
    check("stream_drain_data",  out_data,       TB_BUBBLE);

    // ---- single-cycle stall ----
    in_valid = 1'b1; in_data = 64'hA1; out_ready = 1'b1;
    tick();
    check("s1_first", out_data, 64'hA1);
    out_ready = 1'b0; in_data = 64'hA2;
    tick();
    check("s1_occ2",  64'(occupancy), 64'd2);
    check("s1_rdy0",  64'(in_ready),  64'd0);
    check("s1_head",  out_data,       64'hA1);
    out_ready = 1'b1; in_data = 64'hA3;
    tick();
    check("s1_skid_out", out_data,       64'hA2);
    check("s1_occ1",     64'(occupancy), 64'd1);
    check("s1_rdy1",     64'(in_ready),  64'd1);
    tick();
    check("s1_third", out_data, 64'hA3);
    in_valid = 1'b0;
    tick();
    check("s1_empty", 64'(out_valid), 64'd0);

    // ---- long stall: out_ready low for 10 cycles ----
    in_valid = 1'b1; in_data = 64'hB1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_data = 64'hB2;
    low_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (!in_ready) low_cnt++;
      tick();
      in_data = 64'hB3;
    end
    check("ls_rdy_low_cycles", 64'(low_cnt),     64'd9);
    check("ls_occ2",           64'(occupancy),   64'd2);
    check("ls_head",           out_data,         64'hB1);
    out_ready = 1'b1;
    tick();
    check("ls_drain1", out_data,       64'hB2);
    check("ls_occ1",   64'(occupancy), 64'd1);
    tick();
    check("ls_drain2", out_data, 64'hB3);
    in_valid = 1'b0;
    tick();
    check("ls_empty", 64'(out_valid), 64'd0);

    // ---- flush while in SKID ----
    in_valid = 1'b1; in_data = 64'hC1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_data = 64'hC2;
    tick();
    check("fl_pre_occ", 64'(occupancy), 64'd2);
    flush = 1'b1; in_data = 64'hC3; out_ready = 1'b1;
    tick();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_data",  out_data,       TB_BUBBLE);
    check("fl_occ",   64'(occupancy), 64'd0);
    check("fl_rdy",   64'(in_ready),  64'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("fl_no_accept", 64'(out_valid), 64'd0);

    // ---- clk_en gating ----
    in_valid = 1'b1; in_data = 64'hD1; out_ready = 1'b1;
    tick();
    check("ce_load", out_data, 64'hD1);
    clk_en = 1'b0; in_data = 64'hD2;
    for (int i = 0; i < 4; i++) begin
      in_valid  = i[0];
      out_ready = ~i[1];
      tick();
      check($sformatf("ce_data_%0d", i),  out_data,       64'hD1);
      check($sformatf("ce_valid_%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("ce_occ_%0d", i),   64'(occupancy), 64'd1);
    end
    flush = 1'b1;
    tick();
    check("ce_flush_occ",  64'(occupancy), 64'd0);
    check("ce_flush_data", out_data,       TB_BUBBLE);
    flush = 1'b0; clk_en = 1'b1; in_valid = 1'b0;

    // ---- asynchronous reset while FULL ----
    in_valid = 1'b1; in_data = 64'hE1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("ar_full", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_data",  out_data,       TB_BUBBLE);
    check("ar_occ",   64'(occupancy), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("ar_rdy_after", 64'(in_ready),  64'd1);
    check("ar_still_empty", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
